// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-entry FIFO control stage.
package fifo_pkg;

  localparam int unsigned DEPTH = 8;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    NO_OP  = 3'd1,
    WRITE  = 3'd2,
    WR_ERR = 3'd3,
    READ   = 3'd4,
    RD_ERR = 3'd5
  } state_e;

endpackage

// File: rtl/fifo_ns.sv
// Next-state selection for the FIFO controller: request + occupancy -> state.
module fifo_ns
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = 3
) (
  input  state_e            state,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   count,
  output state_e            state_nx
);

  logic is_full;
  logic is_empty;

  always_comb begin
    is_full  = (count == (ADDR_W + 1)'(DEPTH));
    is_empty = (count == '0);
    state_nx = NO_OP;
    // Write wins over a simultaneous read; the read is dropped silently.
    if (state == INIT) begin
      state_nx = NO_OP;
    end else if (wr_en) begin
      state_nx = is_full ? WR_ERR : WRITE;
    end else if (rd_en) begin
      state_nx = is_empty ? RD_ERR : READ;
    end
  end

endmodule

// File: rtl/fifo_controller.sv
// FIFO control stage: pointers, occupancy and registered strobes/flags for
// the write decoder, register file and read mux.
module fifo_controller
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [DATA_W-1:0] wdata,
  output logic              re,
  output logic [ADDR_W-1:0] rAddr,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err,
  output logic [ADDR_W:0]   count
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   head_q, head_d;
  logic [ADDR_W-1:0]   tail_q, tail_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                re_q, re_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                wr_ack_q, wr_ack_d;
  logic                wr_err_q, wr_err_d;
  logic                rd_ack_q, rd_ack_d;
  logic                rd_err_q, rd_err_d;

  fifo_ns #(.ADDR_W(ADDR_W)) u_ns (
    .state    (state_q),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .count    (count_q),
    .state_nx (state_d)
  );

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    raddr_d  = raddr_q;
    we_d     = 1'b0;
    re_d     = 1'b0;
    wr_ack_d = 1'b0;
    wr_err_d = 1'b0;
    rd_ack_d = 1'b0;
    rd_err_d = 1'b0;
    // Outputs follow the state being entered, so each is a one-cycle pulse.
    unique case (state_d)
      WRITE: begin
        we_d     = 1'b1;
        wr_ack_d = 1'b1;
        waddr_d  = tail_q;
        wdata_d  = din;
        tail_d   = tail_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      WR_ERR: wr_err_d = 1'b1;
      READ: begin
        re_d     = 1'b1;
        rd_ack_d = 1'b1;
        raddr_d  = head_q;
        head_d   = head_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
      RD_ERR: rd_err_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= INIT;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      re_q     <= 1'b0;
      raddr_q  <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      re_q     <= re_d;
      raddr_q  <= raddr_d;
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
      rd_ack_q <= rd_ack_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign we     = we_q;
  assign wAddr  = waddr_q;
  assign wdata  = wdata_q;
  assign re     = re_q;
  assign rAddr  = raddr_q;
  assign wr_ack = wr_ack_q;
  assign wr_err = wr_err_q;
  assign rd_ack = rd_ack_q;
  assign rd_err = rd_err_q;
  assign count  = count_q;
  assign full   = (count_q == (ADDR_W + 1)'(DEPTH));
  assign empty  = (count_q == '0);

endmodule

// File: tb/tb_fifo_controller.sv
// Self-checking bench for fifo_controller against a queue-based FIFO model.
module tb_fifo_controller;
  import fifo_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 3;

  logic              clk;
  logic              reset_n;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] din;
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic [DATA_W-1:0] wdata;
  logic              re;
  logic [ADDR_W-1:0] rAddr;
  logic              full;
  logic              empty;
  logic              wr_ack;
  logic              wr_err;
  logic              rd_ack;
  logic              rd_err;
  logic [ADDR_W:0]   count;

  fifo_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .din     (din),
    .we      (we),
    .wAddr   (wAddr),
    .wdata   (wdata),
    .re      (re),
    .rAddr   (rAddr),
    .full    (full),
    .empty   (empty),
    .wr_ack  (wr_ack),
    .wr_err  (wr_err),
    .rd_ack  (rd_ack),
    .rd_err  (rd_err),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents as a queue, slot indices from request totals.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] mem [8];
  int unsigned wr_total, rd_total;
  bit          in_init;
  bit          e_we, e_re, e_wack, e_werr, e_rack, e_rerr;
  int unsigned e_waddr, e_raddr;
  logic [DATA_W-1:0] e_wdata, e_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    wr_total = 0;
    rd_total = 0;
    in_init  = 1'b1;
    e_we = 0; e_re = 0; e_wack = 0; e_werr = 0; e_rack = 0; e_rerr = 0;
    e_waddr = 0; e_raddr = 0; e_wdata = '0;
  endtask

  task automatic check_outputs();
    chk("we", 64'(we), 64'(e_we));
    chk("re", 64'(re), 64'(e_re));
    chk("wAddr", 64'(wAddr), 64'(e_waddr));
    chk("wdata", 64'(wdata), 64'(e_wdata));
    chk("rAddr", 64'(rAddr), 64'(e_raddr));
    chk("wr_ack", 64'(wr_ack), 64'(e_wack));
    chk("wr_err", 64'(wr_err), 64'(e_werr));
    chk("rd_ack", 64'(rd_ack), 64'(e_rack));
    chk("rd_err", 64'(rd_err), 64'(e_rerr));
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == 8));
    chk("empty", 64'(empty), 64'(q.size() == 0));
  endtask

  task automatic step(input logic wr, input logic rd, input logic [DATA_W-1:0] d);
    wr_en = wr;
    rd_en = rd;
    din   = d;
    @(posedge clk);
    #1;
    e_we = 0; e_re = 0; e_wack = 0; e_werr = 0; e_rack = 0; e_rerr = 0;
    if (in_init) begin
      in_init = 1'b0;
    end else if (wr) begin
      if (q.size() < 8) begin
        e_we = 1; e_wack = 1;
        e_waddr = wr_total % 8;
        e_wdata = d;
        mem[e_waddr] = d;
        q.push_back(d);
        wr_total++;
      end else begin
        e_werr = 1;
      end
    end else if (rd) begin
      if (q.size() > 0) begin
        e_re = 1; e_rack = 1;
        e_raddr = rd_total % 8;
        e_rdata = q.pop_front();
        rd_total++;
      end else begin
        e_rerr = 1;
      end
    end
    check_outputs();
    if (e_re) chk("rdata", 64'(mem[rAddr]), 64'(e_rdata));
  endtask

  initial begin
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("state_reset", 64'(dut.state_q), 64'(INIT));
    @(negedge clk);
    reset_n = 1'b1;

    // INIT edge ignores the write request, then idle
    step(1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("state_after_init", 64'(dut.state_q), 64'(NO_OP));
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h10 + 32'(i));
    chk("full_after_fill", 64'(full), 64'd1);
    step(1'b1, 1'b0, 32'h99);
    chk("overflow_err", 64'(wr_err), 64'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);
    chk("empty_after_drain", 64'(empty), 64'd1);
    step(1'b0, 1'b1, '0);
    chk("underflow_err", 64'(rd_err), 64'd1);

    // Wrap-around: pointers land at 5, then six writes wrap 7 -> 0
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h20 + 32'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 32'h30 + 32'(i));
      chk("wrap_waddr", 64'(wAddr), 64'((5 + i) % 8));
    end
    chk("wrap_count", 64'(count), 64'd6);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, '0);
      chk("wrap_raddr", 64'(rAddr), 64'((5 + i) % 8));
    end

    // Simultaneous requests at count 3 and at count 8
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h40 + 32'(i));
    step(1'b1, 1'b1, 32'h43);
    chk("simul_count", 64'(count), 64'd4);
    chk("simul_rd_ack", 64'(rd_ack), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h50 + 32'(i));
    step(1'b1, 1'b1, 32'h60);
    chk("simul_full_err", 64'(wr_err), 64'd1);
    chk("simul_full_count", 64'(count), 64'd8);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'(($urandom % 2)), 1'(($urandom % 2)), $urandom);
    end

    // Burst from a clean state, reset pulsed while the 4th write strobe is active
    reset_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h70 + 32'(i));
    chk("burst_4th_we", 64'(we), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("state_async_reset", 64'(dut.state_q), 64'(INIT));
    wr_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 1'b0, 32'h80);
    step(1'b1, 1'b0, 32'h81);
    chk("post_reset_waddr", 64'(wAddr), 64'd0);
    chk("post_reset_we", 64'(we), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_controller.md
# fifo_controller

Control stage of the 8-entry FIFO, directly upstream of the write-enable decoder and read multiplexer. Accepts wr_en/rd_en requests, tracks head/tail pointers and occupancy, and drives the registered write strobe, write address and write data into the decoder and register file. It also drives the read strobe and read address into the output mux, with full/empty status and per-request ack/error flags.

## Interface
Parameters:
- DATA_W, 32, width of a FIFO word.
- ADDR_W, 3, pointer width; depth = 2**ADDR_W = 8. Fixed at 3 to match the 3-to-8 write decoder.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request, sampled at the rising edge.
- rd_en  in  1  read request, sampled at the rising edge.
- din  in  DATA_W  data to write; sampled with wr_en.
- we  out  1  registered write strobe to the write decoder.
- wAddr  out  ADDR_W  registered slot index to the write decoder.
- wdata  out  DATA_W  registered write data to the register file.
- re  out  1  registered read strobe to the read mux.
- rAddr  out  ADDR_W  registered slot index to the read mux.
- full  out  1  count == 8.
- empty  out  1  count == 0.
- wr_ack, wr_err, rd_ack, rd_err  out  1 each  registered result of the last sampled request.
- count  out  ADDR_W+1  occupancy, 0..8.

## Operation
- States: INIT, NO_OP, WRITE, WR_ERR, READ, RD_ERR.
- Reset value of every output:
  - state = INIT.
  - head, tail, count = 0.
  - we, re, all ack/err flags = 0.
  - wAddr, rAddr, wdata = 0.
  - empty = 1, full = 0.
- INIT: the first edge after reset_n rises goes to NO_OP. Requests sampled on that edge are ignored.
- From any other state, the request at each edge selects the next state:
  - wr_en=1, not full: WRITE.
    - wAddr <= tail, wdata <= din, we <= 1, wr_ack <= 1.
    - tail <= tail+1 (mod 8), count <= count+1.
  - wr_en=1, full: WR_ERR.
    - wr_err <= 1; pointers, count and wdata unchanged; we <= 0.
  - wr_en=0, rd_en=1, not empty: READ.
    - rAddr <= head, re <= 1, rd_ack <= 1.
    - head <= head+1 (mod 8), count <= count-1.
  - wr_en=0, rd_en=1, empty: RD_ERR.
    - rd_err <= 1; no pointer change; re <= 0.
  - neither request: NO_OP; all strobes and flags 0.
- Simultaneous wr_en and rd_en: write has priority and the read is dropped (no rd_err). Same rule when full: result is WR_ERR.
- Strobes and flags are single-cycle. Each edge recomputes them, so back-to-back requests produce back-to-back pulses.
- Pointer wrap: 3-bit natural overflow, 7 -> 0. Count saturation is impossible by construction.
- full and empty are combinational from the count register.
- Reset asserted mid-operation: immediate return to the reset values. Buffered contents are logically discarded; the register file is not cleared.

## Timing
- Request sampled at edge N; we/wAddr/wdata (or re/rAddr) and ack/err are valid from edge N to edge N+1.
- The decoder is combinational, so the register file captures wdata at edge N+1. Write latency: 1 cycle from request to strobe, 2 edges to storage.
- full/empty/count reflect edge-N updates immediately after edge N. A request at edge N+1 sees the updated status.
- Read data is valid at the mux output during cycle N..N+1, combinationally from rAddr.

## Structure
- Shared package fifo_pkg holds:
  - the state encoding (3-bit: INIT, NO_OP, WRITE, WR_ERR, READ, RD_ERR);
  - DEPTH = 8.
- Natural sub-module: fifo_ns, the combinational next-state logic (state, wr_en, rd_en, count) -> next state.
- The top holds the state, pointer, count and output registers.

## Test plan
- Reset, then idle: state INIT -> NO_OP; empty=1, full=0, count=0; we=re=0 throughout.
- Eight writes of din=0x10..0x17:
  - we pulses with wAddr 0..7 and wdata 0x10..0x17;
  - full=1 after the 8th write;
  - a 9th write gives wr_err=1, we=0, count stays 8.
- Eight reads after fill: rAddr 0..7 and rd_ack each cycle, empty=1 after the last; a 9th read gives rd_err=1, re=0.
- Wrap-around: write 5, read 5, write 6. wAddr sequence is 5,6,7,0,1,2; count=6; then reads give rAddr 5,6,7,0,1,2.
- Simultaneous wr_en and rd_en:
  - with count=3: write performed, count=4, rd_ack=0;
  - with count=8: wr_err=1, count stays 8, no read.
- Reset pulse during the 4th write of a burst: all outputs return to the reset values asynchronously; the next write after release goes to wAddr=0.
